// File: rtl/mipse_boot_ctrl_if.sv
// Stream, instruction-memory write and core run-control signals between the
// boot controller (slave) and the host/core side (master).
interface mipse_boot_ctrl_if #(
    parameter int IMEM_AW = 8,
    parameter int CYCLE_W = 32
);
    // Stream handshake: a byte moves on a rising edge where in_valid & in_ready;
    // in_ready depends only on controller state, never on in_valid.
    logic               in_valid;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_rst_n;
    logic               finish;
    logic               restart;
    logic               done;
    logic               timeout;
    logic               load_err;
    logic [CYCLE_W-1:0] cycles;

    modport master (
        output in_valid, in_byte, finish, restart,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
               done, timeout, load_err, cycles
    );

    modport slave (
        input  in_valid, in_byte, finish, restart,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rst_n,
               done, timeout, load_err, cycles
    );
endinterface

// File: rtl/mipse_boot_ctrl.sv
// Boot/run sequencer: loads a length-prefixed big-endian program into imem,
// releases the mipse core, and counts cycles until finish or timeout.
module mipse_boot_ctrl #(
    parameter int IMEM_AW    = 8,
    parameter int CYCLE_W    = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    mipse_boot_ctrl_if.slave  bus,
    output logic [2:0]        state_dbg
);
    localparam int DEPTH = 1 << IMEM_AW;

    typedef enum logic [2:0] {
        S_HDR0, S_HDR1, S_LOAD, S_LAUNCH, S_RUN, S_DONE
    } state_t;

    state_t             state;
    logic [7:0]         n_hi;
    logic [15:0]        n_last;
    logic [IMEM_AW-1:0] word_idx;
    logic [1:0]         byte_idx;
    logic [23:0]        word_sh;
    logic               accept;
    logic [15:0]        hdr_n;

    assign bus.in_ready = (state == S_HDR0) || (state == S_HDR1) || (state == S_LOAD);
    assign accept       = bus.in_valid && bus.in_ready;
    assign hdr_n        = {n_hi, bus.in_byte};
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_HDR0;
            n_hi           <= 8'd0;
            n_last         <= 16'd0;
            word_idx       <= '0;
            byte_idx       <= 2'd0;
            word_sh        <= 24'd0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= 32'd0;
            bus.core_rst_n <= 1'b0;
            bus.done       <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.load_err   <= 1'b0;
            bus.cycles     <= '0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                S_HDR0: begin
                    if (accept) begin
                        n_hi  <= bus.in_byte;
                        state <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        // An empty or oversized program never releases the core.
                        if (hdr_n == 16'd0 || int'(hdr_n) > DEPTH) begin
                            bus.load_err <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            n_last   <= hdr_n - 16'd1;
                            word_idx <= '0;
                            byte_idx <= 2'd0;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (byte_idx == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= word_idx;
                            bus.imem_wdata <= {word_sh, bus.in_byte};
                            word_idx       <= word_idx + IMEM_AW'(1);
                            byte_idx       <= 2'd0;
                            if (16'(word_idx) == n_last) state <= S_LAUNCH;
                        end else begin
                            word_sh  <= {word_sh[15:0], bus.in_byte};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                S_LAUNCH: begin
                    bus.core_rst_n <= 1'b1;
                    bus.cycles     <= '0;
                    state          <= S_RUN;
                end
                S_RUN: begin
                    if (bus.finish) begin
                        bus.done <= 1'b1;
                        state    <= S_DONE;
                    end else if (bus.cycles == CYCLE_W'(MAX_CYCLES - 1)) begin
                        bus.cycles     <= CYCLE_W'(MAX_CYCLES);
                        bus.timeout    <= 1'b1;
                        bus.core_rst_n <= 1'b0;
                        state          <= S_DONE;
                    end else begin
                        bus.cycles <= bus.cycles + CYCLE_W'(1);
                    end
                end
                S_DONE: begin
                    // cycles is left alone so the host can read the last run.
                    if (bus.restart) begin
                        bus.done       <= 1'b0;
                        bus.timeout    <= 1'b0;
                        bus.load_err   <= 1'b0;
                        bus.core_rst_n <= 1'b0;
                        state          <= S_HDR0;
                    end
                end
                default: state <= S_HDR0;
            endcase
        end
    end
endmodule

// File: tb/tb_mipse_boot_ctrl.sv
// Self-checking bench for mipse_boot_ctrl: table-driven loads/runs, random
// programs against a behavioural model, and reset/restart sequences.
module tb_mipse_boot_ctrl;
    localparam int AW    = 8;
    localparam int CW    = 32;
    localparam int MAX   = 10;
    localparam int DEPTH = 1 << AW;
    localparam int W     = AW + 32;

    typedef struct {
        int n;
        bit fixed;
        bit gaps;
        int finish_at;
        bit e_done;
        bit e_to;
        bit e_err;
        int e_cyc;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [2:0] state_dbg;

    mipse_boot_ctrl_if #(.IMEM_AW(AW), .CYCLE_W(CW)) bif ();

    mipse_boot_ctrl #(.IMEM_AW(AW), .CYCLE_W(CW), .MAX_CYCLES(MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif.slave),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0]  prog_q[$];
    logic [31:0]  fixed_words[2];
    int last_cycles = 0;
    vec_t vecs[8];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (rst_n && bif.imem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", bif.imem_we, 1'b0);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("imem_addr", bif.imem_addr, e[W-1:32]);
                check("imem_wdata", bif.imem_wdata, e[31:0]);
            end
        end
    end

    // Behavioural run outcome: finish sampled in run cycle k ends with cycles=k,
    // unless the MAX-cycle limit is reached first.
    function automatic void model_run(input int finish_at, output bit d, output bit t, output int cyc);
        if (finish_at >= 0 && finish_at < MAX) begin
            d = 1'b1; t = 1'b0; cyc = finish_at;
        end else begin
            d = 1'b0; t = 1'b1; cyc = MAX;
        end
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_we"},    bif.imem_we,    1'b0);
        check({tag, "_imem_addr"},  bif.imem_addr,  '0);
        check({tag, "_imem_wdata"}, bif.imem_wdata, 32'd0);
        check({tag, "_core_rst_n"}, bif.core_rst_n, 1'b0);
        check({tag, "_done"},       bif.done,       1'b0);
        check({tag, "_timeout"},    bif.timeout,    1'b0);
        check({tag, "_load_err"},   bif.load_err,   1'b0);
        check({tag, "_cycles"},     bif.cycles,     '0);
        check({tag, "_in_ready"},   bif.in_ready,   1'b1);
    endtask

    // ---------------- drivers (called just after a negedge) ----------------
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bif.in_valid = 1'b0;
                bif.in_byte  = 8'($urandom);
                @(negedge clk);
            end
        end
        bif.in_valid = 1'b1;
        bif.in_byte  = b;
        check("in_ready_on_send", bif.in_ready, 1'b1);
        @(negedge clk);
        bif.in_valid = 1'b0;
    endtask

    task automatic restart_pulse();
        bif.restart = 1'b1;
        @(negedge clk);
        bif.restart = 1'b0;
        check("rs_done",       bif.done,       1'b0);
        check("rs_timeout",    bif.timeout,    1'b0);
        check("rs_load_err",   bif.load_err,   1'b0);
        check("rs_core_rst_n", bif.core_rst_n, 1'b0);
        check("rs_in_ready",   bif.in_ready,   1'b1);
        check("rs_cycles_hold", bif.cycles,    CW'(last_cycles));
    endtask

    task automatic run_case(input vec_t v);
        logic [15:0] n16;
        logic [31:0] w;
        bit ended;
        n16 = 16'(v.n);
        prog_q.delete();
        if (v.n >= 1 && v.n <= DEPTH) begin
            for (int i = 0; i < v.n; i++) begin
                w = v.fixed ? fixed_words[i] : $urandom;
                prog_q.push_back(w);
                exp_q.push_back({AW'(i), w});
            end
        end
        send_byte(n16[15:8], v.gaps);
        send_byte(n16[7:0], v.gaps);
        if (v.e_err) begin
            check("err_load_err", bif.load_err, 1'b1);
            check("err_in_ready", bif.in_ready, 1'b0);
            repeat (3) @(negedge clk);
            check("err_core_rst_n", bif.core_rst_n, 1'b0);
            check("err_done",       bif.done,       1'b0);
            check("err_no_writes",  exp_q.size(),   0);
            return;
        end
        foreach (prog_q[i]) begin
            w = prog_q[i];
            for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], v.gaps);
        end
        check("launch_core_rst_n", bif.core_rst_n, 1'b0);
        @(negedge clk);
        check("release_core_rst_n", bif.core_rst_n, 1'b1);
        check("release_cycles",     bif.cycles,     '0);
        check("all_writes_seen",    exp_q.size(),   0);
        ended = 1'b0;
        for (int k = 0; k < MAX + 5 && !ended; k++) begin
            bif.finish   = (k == v.finish_at);
            bif.in_valid = 1'($urandom_range(0, 1));
            bif.in_byte  = 8'($urandom);
            @(negedge clk);
            ended = bif.done || bif.timeout;
        end
        bif.finish   = 1'b0;
        bif.in_valid = 1'b0;
        check("run_ended",      ended,          1'b1);
        check("end_done",       bif.done,       v.e_done);
        check("end_timeout",    bif.timeout,    v.e_to);
        check("end_load_err",   bif.load_err,   1'b0);
        check("end_cycles",     bif.cycles,     CW'(v.e_cyc));
        check("end_core_rst_n", bif.core_rst_n, v.e_done);
        check("end_in_ready",   bif.in_ready,   1'b0);
        last_cycles = v.e_cyc;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t rv;
        bit d, t;
        int c;
        logic [31:0] w0;

        fixed_words[0] = 32'h2008_0005;
        fixed_words[1] = 32'h1000_FFFF;
        //            n    fix gap fin  done to err cyc
        vecs[0] = '{  2,   1,  0,  7,   1,  0, 0,  7};
        vecs[1] = '{  1,   0,  1,  0,   1,  0, 0,  0};
        vecs[2] = '{  3,   0,  0, -1,   0,  1, 0, 10};
        vecs[3] = '{  0,   0,  0, -1,   0,  0, 1,  0};
        vecs[4] = '{257,   0,  1, -1,   0,  0, 1,  0};
        vecs[5] = '{  4,   0,  1,  9,   1,  0, 0,  9};
        vecs[6] = '{  2,   0,  0, 10,   0,  1, 0, 10};
        vecs[7] = '{256,   0,  0,  3,   1,  0, 0,  3};

        bif.in_valid = 1'b0;
        bif.in_byte  = 8'd0;
        bif.finish   = 1'b0;
        bif.restart  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (i != 0) restart_pulse();
            run_case(vecs[i]);
        end

        for (int r = 0; r < 6; r++) begin
            rv.n         = $urandom_range(1, 6);
            rv.fixed     = 1'b0;
            rv.gaps      = 1'($urandom_range(0, 1));
            rv.finish_at = $urandom_range(0, 12);
            model_run(rv.finish_at, d, t, c);
            rv.e_done = d;
            rv.e_to   = t;
            rv.e_err  = 1'b0;
            rv.e_cyc  = c;
            restart_pulse();
            run_case(rv);
        end

        // Reset in the middle of a load: one complete word, then a partial one.
        restart_pulse();
        w0 = $urandom;
        exp_q.push_back({AW'(0), w0});
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        for (int b = 3; b >= 0; b--) send_byte(w0[b*8 +: 8], 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        check("partial_writes_seen", exp_q.size(), 0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_load_rst");
        @(negedge clk);
        rst_n = 1'b1;
        last_cycles = 0;
        rv = '{2, 0, 1, 4, 1, 0, 0, 4};
        run_case(rv);

        // New one-word program after a completed run.
        restart_pulse();
        rv = '{1, 0, 0, 2, 1, 0, 0, 2};
        run_case(rv);

        repeat (2) @(negedge clk);
        $display("info: final state_dbg=%0d", state_dbg);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/mipse_boot_ctrl.md
# mipse_boot_ctrl

Boot/run sequencer for the single-cycle `mipse` core. It receives a program as a byte stream with a valid/ready handshake and writes it word-by-word into instruction memory, holding the core in reset while it does so. It then releases the core, counts execution cycles until the core raises `finish` or a timeout expires, and reports status. It sits between the host/testbench stream source and the core's instruction memory and reset pin.

## Interface
Parameters:
- `IMEM_AW`, 8: instruction memory word-address bits. Depth = 2^IMEM_AW words.
- `CYCLE_W`, 32: width of the cycle counter.
- `MAX_CYCLES`, 100000: run-cycle limit before timeout. Must be ≥1 and < 2^CYCLE_W.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: stream byte valid.
- `in_byte` in 8: stream byte.
- `in_ready` out 1: controller accepts a byte this cycle.
- `imem_we` out 1: instruction memory write strobe, one cycle per word.
- `imem_addr` out IMEM_AW: word address of the write.
- `imem_wdata` out 32: word to write.
- `core_rst_n` out 1: active-low reset driven to the core.
- `finish` in 1: core finished flag.
- `restart` in 1: single-cycle pulse that starts a new load from DONE.
- `done` out 1: run ended with `finish`.
- `timeout` out 1: run ended at `MAX_CYCLES`.
- `load_err` out 1: header word count was illegal.
- `cycles` out CYCLE_W: cycles executed in the last run.

## Operation
- Stream format:
  - Byte 0 and byte 1 form the word count N, a 16-bit big-endian value (byte 0 is the MSB).
  - N words follow, 4 bytes each, big-endian. The first byte of a word goes to `imem_wdata[31:24]`.
- A byte is accepted on a rising edge where `in_valid & in_ready`. `in_ready` is combinational and equals `state ∈ {HDR0, HDR1, LOAD}`.
- States and transitions:
  - HDR0: on accept, latch N[15:8] and go to HDR1.
  - HDR1: on accept, latch N[7:0].
    - If N==0 or N>2^IMEM_AW: set `load_err`=1 and go to DONE. The core is never released.
    - Otherwise: clear the word index and byte index, then go to LOAD.
  - LOAD: shift each accepted byte into the word register. On the 4th byte of a word:
    - Register `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word.
    - Increment the word index and reset the byte index.
    - If this was word N-1, go to LAUNCH.
  - LAUNCH: lasts exactly one cycle, during which the final write is presented. On the next edge:
    - `core_rst_n`=1, `cycles`=0, go to RUN.
  - RUN: on each edge:
    - If `finish`=1: `done`=1, go to DONE. `core_rst_n` stays 1 and the core holds its PC.
    - Else if `cycles`+1 == MAX_CYCLES: `cycles`=MAX_CYCLES, `timeout`=1, `core_rst_n`=0, go to DONE.
    - Else: `cycles`+=1.
  - DONE: `restart`=1 clears `done`, `timeout` and `load_err`, sets `core_rst_n`=0, and goes to HDR0. `cycles` holds its value until the next LAUNCH.
- `restart` is ignored outside DONE. `in_valid` is ignored outside HDR0/HDR1/LOAD. `finish` is ignored outside RUN.
- `imem_we` is high for exactly one cycle per word and never during RUN or DONE.
- Addresses wrap nowhere, because N ≤ depth is enforced at the header.

## Timing
- Reset (asynchronous, effective immediately):
  - state=HDR0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_rst_n`=0, `done`=0, `timeout`=0, `load_err`=0, `cycles`=0.
  - `in_ready`=1 while reset is deasserted.
- Reset mid-load or mid-run aborts immediately. Partial words are discarded and the core is held in reset.
- Write latency: `imem_we` is high in the cycle after the edge that accepted the 4th byte.
- Release latency: `core_rst_n` rises 2 edges after acceptance of the last byte (one edge into LAUNCH, one edge into RUN).
- If `finish` is high in the first RUN cycle, `done`=1 with `cycles`=0.
- Back-to-back bytes (`in_valid` held high) are accepted every cycle, giving a sustained rate of one word per 4 cycles.

## Test plan
- Load N=2, words 0x20080005 and 0x1000FFFF, with `in_valid` always high → `imem_we` pulses at addr 0 then addr 1 with those data, 4 cycles apart. `core_rst_n` rises 2 cycles after the last byte.
- After launch, assert `finish` 7 cycles after `core_rst_n` rises → `done`=1, `cycles`=7, `core_rst_n` stays 1, `in_ready`=0.
- MAX_CYCLES=10 with `finish` never asserted → `timeout`=1, `cycles`=10, `core_rst_n`=0 in DONE.
- Header N=0, then a separate run with N=257 at IMEM_AW=8 → `load_err`=1, no `imem_we` pulses, `core_rst_n` stays 0.
- `in_valid` toggled randomly mid-word, then `rst_n` pulsed low after 6 bytes → words assemble correctly despite gaps. Reset returns all outputs to reset values and a fresh full load succeeds.
- From DONE, pulse `restart` and load a new 1-word program → flags clear, the new word is written at addr 0, and `cycles` restarts from 0.
